// File: rtl/unidad_control_multiciclo.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/write-back with memory-ready stalls.
// Optional macro UC_EXCEPTION_EN: illegal opcodes redirect the PC to the exception vector.
module unidad_control_multiciclo #(
   parameter int unsigned OPCODE_W = 6,
   parameter int unsigned ALUOP_W  = 3,
   parameter int unsigned RA_INDEX = 31
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                pc_write_cond,
   output logic [1:0]          branch_type,
   output logic                i_or_d,
   output logic                mem_read,
   output logic                mem_write,
   output logic                ir_write,
   output logic                mem_to_reg,
   output logic [1:0]          pc_source,
   output logic [ALUOP_W-1:0]  alu_op,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic                reg_write,
   output logic                reg_dst,
   output logic                jump_and_link,
   output logic [4:0]          ra_index,
   output logic                illegal_op,
   output logic [3:0]          state
);

   localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
   localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);
   localparam logic [OPCODE_W-1:0] OP_ANDI = OPCODE_W'(6'b001100);
   localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'(6'b001101);
   localparam logic [OPCODE_W-1:0] OP_SLTI = OPCODE_W'(6'b001010);
   localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
   localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);
   localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
   localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(6'b000101);
   localparam logic [OPCODE_W-1:0] OP_BGTZ = OPCODE_W'(6'b000111);
   localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);
   localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(6'b000011);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      EXEC_R   = 4'd2,
      WB_R     = 4'd3,
      EXEC_I   = 4'd4,
      WB_I     = 4'd5,
      MEM_ADDR = 4'd6,
      MEM_RD   = 4'd7,
      WB_MEM   = 4'd8,
      MEM_WR   = 4'd9,
      BRANCH   = 4'd10,
      JUMP     = 4'd11,
      JAL      = 4'd12,
      ILLEGAL  = 4'd13
   } state_t;

   state_t     state_q;
   logic [2:0] alu3;
   logic [2:0] imm_alu;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
      end else begin
         case (state_q)
            FETCH:    if (mem_ready) state_q <= DECODE;
            DECODE: begin
               case (opcode)
                  OP_R:                              state_q <= EXEC_R;
                  OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_q <= EXEC_I;
                  OP_LW, OP_SW:                      state_q <= MEM_ADDR;
                  OP_BEQ, OP_BNE, OP_BGTZ:           state_q <= BRANCH;
                  OP_J:                              state_q <= JUMP;
                  OP_JAL:                            state_q <= JAL;
                  default:                           state_q <= ILLEGAL;
               endcase
            end
            EXEC_R:   state_q <= WB_R;
            EXEC_I:   state_q <= WB_I;
            MEM_ADDR: state_q <= (opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   if (mem_ready) state_q <= WB_MEM;
            MEM_WR:   if (mem_ready) state_q <= FETCH;
            default:  state_q <= FETCH;
         endcase
      end
   end

   // IR is stable until the next FETCH, so the opcode can be re-decoded in later states.
   always_comb begin
      case (opcode)
         OP_ANDI: imm_alu = 3'b100;
         OP_ORI:  imm_alu = 3'b101;
         OP_SLTI: imm_alu = 3'b111;
         default: imm_alu = 3'b000;
      endcase
   end

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      branch_type   = 2'b00;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      pc_source     = 2'b00;
      alu3          = 3'b000;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      jump_and_link = 1'b0;
      illegal_op    = 1'b0;
      // Strobes are suppressed for the whole reset cycle, whatever the current state.
      if (!reset) begin
         case (state_q)
            FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            DECODE: alu_src_b = 2'b11;
            EXEC_R: begin
               alu_src_a = 1'b1;
               alu3      = 3'b010;
            end
            WB_R: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
               alu3      = 3'b010;
            end
            EXEC_I: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               alu3      = imm_alu;
            end
            WB_I: begin
               reg_write = 1'b1;
               alu3      = imm_alu;
            end
            MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            MEM_RD: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
            end
            WB_MEM: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            MEM_WR: begin
               mem_write = 1'b1;
               i_or_d    = 1'b1;
            end
            BRANCH: begin
               alu_src_a     = 1'b1;
               pc_write_cond = 1'b1;
               pc_source     = 2'b01;
               if (opcode == OP_BGTZ) begin
                  alu3        = 3'b110;
                  branch_type = 2'b10;
               end else begin
                  alu3        = 3'b001;
                  branch_type = (opcode == OP_BNE) ? 2'b01 : 2'b00;
               end
            end
            JUMP: begin
               pc_write  = 1'b1;
               pc_source = 2'b10;
            end
            JAL: begin
               pc_write      = 1'b1;
               pc_source     = 2'b10;
               reg_write     = 1'b1;
               jump_and_link = 1'b1;
            end
            ILLEGAL: begin
               illegal_op = 1'b1;
`ifdef UC_EXCEPTION_EN
               pc_write   = 1'b1;
               pc_source  = 2'b11;
`endif
            end
            default: ;
         endcase
      end
   end

   assign alu_op   = ALUOP_W'(alu3);
   assign ra_index = 5'(RA_INDEX);
   assign state    = state_q;

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Table-driven bench for unidad_control_multiciclo: per-cycle expected state/outputs via a scoreboard.
module tb_unidad_control_multiciclo;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] branch_type;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic [1:0] pc_source;
      logic [2:0] alu_op;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       reg_write;
      logic       reg_dst;
      logic       jump_and_link;
      logic       illegal_op;
   } outs_t;

   typedef struct packed {
      logic [3:0] st;
      outs_t      o;
   } exp_t;

   typedef struct packed {
      logic [5:0]      op;
      logic [2:0]      alu;
      logic [1:0]      bt;
      logic [7:0]      mr;
      logic [3:0]      len;
      logic [7:0][3:0] st;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] opcode = 6'd0;
   logic       mem_ready = 1'b0;
   logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg;
   logic       alu_src_a, reg_write, reg_dst, jump_and_link, illegal_op;
   logic [1:0] branch_type, pc_source, alu_src_b;
   logic [2:0] alu_op;
   logic [4:0] ra_index;
   logic [3:0] state;
   outs_t      act;

   exp_t sb_q[$];
   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail = 0;

   unidad_control_multiciclo #(
      .OPCODE_W(6),
      .ALUOP_W (3),
      .RA_INDEX(31)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .opcode       (opcode),
      .mem_ready    (mem_ready),
      .pc_write     (pc_write),
      .pc_write_cond(pc_write_cond),
      .branch_type  (branch_type),
      .i_or_d       (i_or_d),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .ir_write     (ir_write),
      .mem_to_reg   (mem_to_reg),
      .pc_source    (pc_source),
      .alu_op       (alu_op),
      .alu_src_a    (alu_src_a),
      .alu_src_b    (alu_src_b),
      .reg_write    (reg_write),
      .reg_dst      (reg_dst),
      .jump_and_link(jump_and_link),
      .ra_index     (ra_index),
      .illegal_op   (illegal_op),
      .state        (state)
   );

   always #5 clk = ~clk;

   assign act = {pc_write, pc_write_cond, branch_type, i_or_d, mem_read, mem_write, ir_write,
                 mem_to_reg, pc_source, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst,
                 jump_and_link, illegal_op};

   // Expected outputs of each state, written from the state table.
   function automatic outs_t model(input logic [3:0] st, input logic mr, input logic [2:0] alu,
                                   input logic [1:0] bt);
      outs_t o;
      o = '0;
      case (st)
         4'd0: begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr; end
         4'd1: o.alu_src_b = 2'b11;
         4'd2: begin o.alu_src_a = 1; o.alu_op = 3'b010; end
         4'd3: begin o.reg_write = 1; o.reg_dst = 1; o.alu_op = 3'b010; end
         4'd4: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = alu; end
         4'd5: begin o.reg_write = 1; o.alu_op = alu; end
         4'd6: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
         4'd7: begin o.mem_read = 1; o.i_or_d = 1; end
         4'd8: begin o.reg_write = 1; o.mem_to_reg = 1; end
         4'd9: begin o.mem_write = 1; o.i_or_d = 1; end
         4'd10: begin
            o.alu_src_a = 1; o.pc_write_cond = 1; o.pc_source = 2'b01;
            o.alu_op = alu; o.branch_type = bt;
         end
         4'd11: begin o.pc_write = 1; o.pc_source = 2'b10; end
         4'd12: begin
            o.pc_write = 1; o.pc_source = 2'b10; o.reg_write = 1; o.jump_and_link = 1;
         end
         4'd13: begin
            o.illegal_op = 1;
`ifdef UC_EXCEPTION_EN
            o.pc_write = 1; o.pc_source = 2'b11;
`endif
         end
         default: ;
      endcase
      return o;
   endfunction

   function automatic exp_t mk_exp(input logic [3:0] st, input outs_t o);
      exp_t e;
      e.st = st;
      e.o  = o;
      return e;
   endfunction

   function automatic vec_t mk_vec(input logic [5:0] op, input logic [2:0] alu,
                                   input logic [1:0] bt, input logic [7:0] mr,
                                   input logic [3:0] len, input logic [3:0] s0, s1, s2, s3,
                                   s4, s5, s6, s7);
      vec_t v;
      v.op = op; v.alu = alu; v.bt = bt; v.mr = mr; v.len = len;
      v.st[0] = s0; v.st[1] = s1; v.st[2] = s2; v.st[3] = s3;
      v.st[4] = s4; v.st[5] = s5; v.st[6] = s6; v.st[7] = s7;
      return v;
   endfunction

   task automatic check(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         n_checks++; n_fail++;
         $display("FAIL %s scoreboard empty", tag);
         return;
      end
      e = sb_q.pop_front();
      n_checks++;
      if (state !== e.st) begin
         n_fail++;
         $display("FAIL %s state got=%0d want=%0d", tag, state, e.st);
      end
      n_checks++;
      if (act !== e.o) begin
         n_fail++;
         $display("FAIL %s st=%0d outputs got=%h want=%h", tag, e.st, act, e.o);
      end
   endtask

   // Drive one cycle's inputs just after a falling edge, then check before the rising edge.
   task automatic cycle(input string tag, input logic rst, input logic mr, input exp_t e);
      reset     = rst;
      mem_ready = mr;
      sb_q.push_back(e);
      #1;
      check(tag);
      @(negedge clk);
   endtask

   initial begin
      //                op         alu     bt     mr           len  states
      vecs.push_back(mk_vec(6'b000000, 3'b000, 2'b00, 8'hFF, 4'd4, 0, 1, 2, 3, 0, 0, 0, 0));
      vecs.push_back(mk_vec(6'b001000, 3'b000, 2'b00, 8'hFF, 4'd4, 0, 1, 4, 5, 0, 0, 0, 0));
      vecs.push_back(mk_vec(6'b001100, 3'b100, 2'b00, 8'hFF, 4'd4, 0, 1, 4, 5, 0, 0, 0, 0));
      vecs.push_back(mk_vec(6'b001101, 3'b101, 2'b00, 8'hFF, 4'd4, 0, 1, 4, 5, 0, 0, 0, 0));
      vecs.push_back(mk_vec(6'b001010, 3'b111, 2'b00, 8'hFF, 4'd4, 0, 1, 4, 5, 0, 0, 0, 0));
      vecs.push_back(mk_vec(6'b100011, 3'b000, 2'b00, 8'hE7, 4'd7, 0, 1, 6, 7, 7, 7, 8, 0));
      vecs.push_back(mk_vec(6'b101011, 3'b000, 2'b00, 8'hF7, 4'd5, 0, 1, 6, 9, 9, 0, 0, 0));
      vecs.push_back(mk_vec(6'b000100, 3'b001, 2'b00, 8'hFF, 4'd3, 0, 1, 10, 0, 0, 0, 0, 0));
      vecs.push_back(mk_vec(6'b000101, 3'b001, 2'b01, 8'hFF, 4'd3, 0, 1, 10, 0, 0, 0, 0, 0));
      vecs.push_back(mk_vec(6'b000111, 3'b110, 2'b10, 8'hFF, 4'd3, 0, 1, 10, 0, 0, 0, 0, 0));
      vecs.push_back(mk_vec(6'b000010, 3'b000, 2'b00, 8'hFF, 4'd3, 0, 1, 11, 0, 0, 0, 0, 0));
      vecs.push_back(mk_vec(6'b000011, 3'b000, 2'b00, 8'hFF, 4'd3, 0, 1, 12, 0, 0, 0, 0, 0));
      vecs.push_back(mk_vec(6'b111111, 3'b000, 2'b00, 8'hFF, 4'd3, 0, 1, 13, 0, 0, 0, 0, 0));
      vecs.push_back(mk_vec(6'b000000, 3'b000, 2'b00, 8'hFE, 4'd5, 0, 0, 1, 2, 3, 0, 0, 0));
      vecs.push_back(mk_vec(6'b100011, 3'b000, 2'b00, 8'hFF, 4'd5, 0, 1, 6, 7, 8, 0, 0, 0));

      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      cycle("reset", 1'b1, 1'b1, mk_exp(4'd0, '0));

      n_checks++;
      if (ra_index !== 5'd31) begin
         n_fail++;
         $display("FAIL ra_index got=%0d want=31", ra_index);
      end

      foreach (vecs[k]) begin
         opcode = vecs[k].op;
         for (int i = 0; i < int'(vecs[k].len); i++)
            cycle($sformatf("vec%0d_op%b_c%0d", k, vecs[k].op, i), 1'b0, vecs[k].mr[i],
                  mk_exp(vecs[k].st[i], model(vecs[k].st[i], vecs[k].mr[i], vecs[k].alu,
                                              vecs[k].bt)));
      end

      // Reset held two cycles while stalled in MEM_RD, then a fresh fetch and the lw replay.
      opcode = 6'b100011;
      cycle("rst_mid_fetch", 1'b0, 1'b1, mk_exp(4'd0, model(4'd0, 1'b1, 3'b0, 2'b0)));
      cycle("rst_mid_dec", 1'b0, 1'b1, mk_exp(4'd1, model(4'd1, 1'b1, 3'b0, 2'b0)));
      cycle("rst_mid_addr", 1'b0, 1'b1, mk_exp(4'd6, model(4'd6, 1'b1, 3'b0, 2'b0)));
      cycle("rst_mid_rd", 1'b0, 1'b0, mk_exp(4'd7, model(4'd7, 1'b0, 3'b0, 2'b0)));
      cycle("rst_cyc1", 1'b1, 1'b0, mk_exp(4'd7, '0));
      cycle("rst_cyc2", 1'b1, 1'b0, mk_exp(4'd0, '0));
      cycle("rst_rel_fetch", 1'b0, 1'b1, mk_exp(4'd0, model(4'd0, 1'b1, 3'b0, 2'b0)));
      cycle("rst_rel_dec", 1'b0, 1'b1, mk_exp(4'd1, model(4'd1, 1'b1, 3'b0, 2'b0)));
      cycle("rst_rel_addr", 1'b0, 1'b1, mk_exp(4'd6, model(4'd6, 1'b1, 3'b0, 2'b0)));
      cycle("rst_rel_rd", 1'b0, 1'b1, mk_exp(4'd7, model(4'd7, 1'b1, 3'b0, 2'b0)));
      cycle("rst_rel_wb", 1'b0, 1'b1, mk_exp(4'd8, model(4'd8, 1'b1, 3'b0, 2'b0)));
      cycle("rst_rel_back", 1'b0, 1'b1, mk_exp(4'd0, model(4'd0, 1'b1, 3'b0, 2'b0)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/unidad_control_multiciclo.md
Name: unidad_control_multiciclo

Overview:
- Multi-cycle successor to the single-cycle main decoder: an FSM that sequences fetch, decode, execute, memory and write-back over several cycles for the same MIPS subset (R-type, addi, andi, ori, slti, lw, sw, beq, bne, bgtz, j, jal).
- Drives the shared-memory multi-cycle datapath: PC, IR, ALU input muxes and register file.
- Stalls on a memory-ready handshake.

Parameters:
- OPCODE_W, 6, opcode field width.
- ALUOP_W, 3, width of alu_op; values below are zero-extended if ALUOP_W > 3; ALUOP_W >= 3 is required.
- RA_INDEX, 31, register index written by jal; exported on ra_index.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode  input  OPCODE_W  IR[31:26]; valid from DECODE onward.
- mem_ready  input  1  memory completes the current read/write this cycle.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load qualified by the branch condition outside this block.
- branch_type  output  2  00 beq, 01 bne, 10 bgtz.
- i_or_d  output  1  memory address source: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- ir_write  output  1  IR load.
- mem_to_reg  output  1  write-back source: 1 = MDR.
- pc_source  output  2  00 ALU, 01 ALUOut, 10 jump target, 11 exception vector.
- alu_op  output  ALUOP_W  ALU control class.
- alu_src_a  output  1  0 = PC, 1 = rs.
- alu_src_b  output  2  00 rt, 01 const 4, 10 sign-extended imm, 11 imm<<2.
- reg_write  output  1  register file write enable.
- reg_dst  output  1  1 = rd.
- jump_and_link  output  1  write-back selects PC and destination RA_INDEX.
- ra_index  output  5  constant RA_INDEX.
- illegal_op  output  1  one-cycle pulse on an unknown opcode.
- state  output  4  current state, for debug.

Behaviour:
- Reset: synchronous; state = FETCH (0). Output defaults are 0 in every state unless listed below, and are decoded from the registered state. Outputs that depend on mem_ready are noted.
- FETCH (0):
  - mem_read=1, alu_src_b=01, alu_op=000.
  - ir_write and pc_write = mem_ready.
  - Stay while !mem_ready; go to DECODE when mem_ready.
- DECODE (1):
  - alu_src_b=11, alu_op=000 (branch target precompute).
  - Next state by opcode:
    - 000000 -> EXEC_R
    - 001000/001100/001101/001010 -> EXEC_I
    - 100011/101011 -> MEM_ADDR
    - 000100/000101/000111 -> BRANCH
    - 000010 -> JUMP
    - 000011 -> JAL
    - otherwise -> ILLEGAL
- EXEC_R (2): alu_src_a=1, alu_src_b=00, alu_op=010 -> WB_R.
- WB_R (3): reg_write=1, reg_dst=1, alu_op held at 010 -> FETCH.
- EXEC_I (4):
  - alu_src_a=1, alu_src_b=10.
  - alu_op: addi 000, andi 100, ori 101, slti 111.
  - -> WB_I.
- WB_I (5): reg_write=1, reg_dst=0, alu_op held at the EXEC_I value -> FETCH.
- MEM_ADDR (6): alu_src_a=1, alu_src_b=10, alu_op=000 -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD (7): mem_read=1, i_or_d=1; stay until mem_ready -> WB_MEM.
- WB_MEM (8): reg_write=1, mem_to_reg=1 -> FETCH.
- MEM_WR (9): mem_write=1, i_or_d=1; stay until mem_ready -> FETCH.
- BRANCH (10):
  - alu_src_a=1, alu_src_b=00, pc_write_cond=1, pc_source=01.
  - beq/bne: alu_op=001, branch_type 00/01.
  - bgtz: alu_op=110, branch_type 10.
  - -> FETCH.
- JUMP (11): pc_write=1, pc_source=10 -> FETCH.
- JAL (12): pc_write=1, pc_source=10, reg_write=1, jump_and_link=1 -> FETCH.
- ILLEGAL (13): see Optional Feature.
- Latency:
  - Each mem_ready wait adds one cycle per low cycle.
  - R/I-type: 4 cycles; lw 5; sw 4; branch/j/jal 3 (zero-wait memory).
- Opcode sampling: opcode is sampled in DECODE only, and again in the states that follow it, since IR is stable until the next FETCH.
- Reset mid-instruction: any state returns to FETCH next edge with all outputs 0. No strobe is asserted in the reset cycle.
- Reserved states: unused codes 14 and 15 go to FETCH.

Optional Feature:
- Macro: UC_EXCEPTION_EN.
- Defined:
  - ILLEGAL asserts illegal_op=1, pc_write=1, pc_source=11 for one cycle -> FETCH.
- Undefined:
  - ILLEGAL behaves as a NOP: illegal_op=1 for one cycle, no pc_write -> FETCH.
  - The PC was already advanced in FETCH.
  - pc_source value 11 is never driven.

Test Plan:
- Reset held 2 cycles mid-MEM_RD -> state=0, all strobes 0. After release with mem_ready=1, mem_read=1 and ir_write=1 in cycle 1.
- opcode 000000, mem_ready=1 -> states 0,1,2,3,0. alu_op=010 in 2–3; reg_write=1, reg_dst=1 only in state 3.
- lw (100011), mem_ready low 2 cycles in MEM_RD -> 0,1,6,7,7,7,8,0. mem_to_reg=1 and reg_write=1 only in 8.
- bgtz (000111) -> BRANCH with alu_op=110, branch_type=10, pc_write_cond=1. ori (001101) -> EXEC_I alu_op=101.
- jal (000011) -> 0,1,12,0. State 12 has pc_write=1, pc_source=10, reg_write=1, jump_and_link=1; ra_index=31.
- opcode 111111 -> ILLEGAL, illegal_op pulse. With UC_EXCEPTION_EN: pc_source=11, pc_write=1. Without: pc_write=0.
